// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the exception controller: CP0 register addresses,
// exception codes, MEM exception-flag bit positions and the FSM state type.
package exc_ctrl_pkg;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TR   = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam int EXC_BIT_ADEL_IF = 0;
  localparam int EXC_BIT_RI      = 1;
  localparam int EXC_BIT_OV      = 2;
  localparam int EXC_BIT_TRAP    = 3;
  localparam int EXC_BIT_SYSCALL = 4;
  localparam int EXC_BIT_BREAK   = 5;
  localparam int EXC_BIT_ADEL_LS = 6;
  localparam int EXC_BIT_ADES    = 7;
  localparam int EXC_BIT_ERET    = 8;
  localparam int EXC_BIT_RSVD    = 9;

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } exc_state_e;

  // Address-error codes are the only ones that report a faulting address.
  function automatic logic isAddrFault(input logic [31:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder: picks one exception code from the MEM flag vector
// and the interrupt-pending bit, and reports whether anything is to be taken.
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic [9:0]  i_exc,
  input  logic        i_int_pending,
  output logic [31:0] o_code,
  output logic        o_take
);

  logic w_unused_rsvd;
  assign w_unused_rsvd = i_exc[EXC_BIT_RSVD];

  always_comb begin
    o_code = '0;
    if (i_int_pending)                o_code = EXC_INT;
    else if (i_exc[EXC_BIT_ADEL_IF])  o_code = EXC_ADEL;
    else if (i_exc[EXC_BIT_RI])       o_code = EXC_RI;
    else if (i_exc[EXC_BIT_OV])       o_code = EXC_OV;
    else if (i_exc[EXC_BIT_TRAP])     o_code = EXC_TR;
    else if (i_exc[EXC_BIT_SYSCALL])  o_code = EXC_SYS;
    else if (i_exc[EXC_BIT_BREAK])    o_code = EXC_BP;
    else if (i_exc[EXC_BIT_ADEL_LS])  o_code = EXC_ADEL;
    else if (i_exc[EXC_BIT_ADES])     o_code = EXC_ADES;
    else if (i_exc[EXC_BIT_ERET])     o_code = EXC_ERET;
    o_take = i_int_pending | (|i_exc[8:0]);
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller between MEM and CP0: selects one exception,
// pulses the CP0 update and sequences the flush/redirect.
// Optional: define EXC_CTRL_IRQ_SYNC_EN to pass int_i through a 2-flop synchronizer.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        mem_valid_i,
  input  logic        mem_stall_i,
  input  logic [9:0]  mem_exc_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] mem_bad_addr_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  exc_state_e  r_state;
  exc_state_e  w_state_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_excepttype;
  logic [31:0] r_inst_addr;
  logic        r_in_ds;
  logic [31:0] r_bad_addr;
  logic        r_flush;
  logic [31:0] r_new_pc;

  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic [31:0] w_epc;
  logic [5:0]  w_int;
  logic        w_int_pending;
  logic [31:0] w_code;
  logic        w_any;
  logic        w_take;
  logic        w_unused;

  // WB-stage CP0 writes are not yet visible in the CP0 file, so forward them.
  assign w_status = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_REG_STATUS) ? wb_cp0_data_i : cp0_status_i;
  assign w_cause  = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_REG_CAUSE)
                    ? {cp0_cause_i[31:10], wb_cp0_data_i[9:8], cp0_cause_i[7:0]} : cp0_cause_i;
  assign w_epc    = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_REG_EPC) ? wb_cp0_data_i : cp0_epc_i;

  assign w_unused = ^{w_status[31:16], w_status[7:2], w_cause[31:16], w_cause[7:0]};

`ifdef EXC_CTRL_IRQ_SYNC_EN
  logic [5:0] r_int_meta;
  logic [5:0] r_int_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_meta <= '0;
      r_int_sync <= '0;
    end else begin
      r_int_meta <= int_i;
      r_int_sync <= r_int_meta;
    end
  end

  assign w_int = r_int_sync;
`else
  assign w_int = int_i;
`endif

  assign w_int_pending = w_status[0] & ~w_status[1] &
                         ((|((w_cause[15:10] | w_int) & w_status[15:10])) |
                          (|(w_cause[9:8] & w_status[9:8])));

  exc_prio_enc u_prio_enc (
    .i_exc         (mem_exc_i),
    .i_int_pending (w_int_pending),
    .o_code        (w_code),
    .o_take        (w_any)
  );

  // Bubbles and stalls never take, so EPC always names a real, advancing instruction.
  assign w_take = (r_state == ST_IDLE) & mem_valid_i & ~mem_stall_i & w_any;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_take) w_state_next = ST_FLUSH;
      ST_FLUSH: if (r_cnt == 4'd0) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_excepttype <= '0;
      r_inst_addr  <= '0;
      r_in_ds      <= 1'b0;
      r_bad_addr   <= '0;
      r_flush      <= 1'b0;
      r_new_pc     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_excepttype <= w_take ? w_code : '0;
      if (w_take) begin
        r_inst_addr <= mem_pc_i;
        r_in_ds     <= mem_in_delayslot_i;
        r_bad_addr  <= isAddrFault(w_code) ? mem_bad_addr_i : '0;
        r_flush     <= 1'b1;
        r_new_pc    <= (w_code == EXC_ERET) ? w_epc : EXC_VECTOR;
        r_cnt       <= FLUSH_LOAD;
      end else if (r_state == ST_FLUSH) begin
        if (r_cnt == 4'd0) begin
          r_flush  <= 1'b0;
          r_new_pc <= '0;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  assign excepttype_o        = r_excepttype;
  assign current_inst_addr_o = r_inst_addr;
  assign is_in_delayslot_o   = r_in_ds;
  assign bad_addr_o          = r_bad_addr;
  assign flush_o             = r_flush;
  assign new_pc_o            = r_new_pc;

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception and interrupt controller sitting between the MEM stage and the CP0 register file.
- Collects per-instruction exception flags from MEM and evaluates pending interrupts against the forwarded Status and Cause registers.
- Selects a single exception by fixed priority and drives the CP0 exception-update inputs for exactly one cycle.
- Sequences the pipeline flush and PC redirect through a small state machine.

Parameters:
- EXC_VECTOR, 32'hBFC00380, handler entry PC used for all exceptions except ERET.
- FLUSH_CYCLES, 1, number of cycles flush_o stays high per taken exception; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high (RstEnable)
- int_i  in  6  raw hardware interrupt lines, IP7..IP2
- mem_valid_i  in  1  MEM holds a real instruction (not a bubble)
- mem_stall_i  in  1  MEM stalled; hold off any decision
- mem_exc_i  in  10  flags: [0]adel_if [1]ri [2]ov [3]trap [4]syscall [5]break [6]adel_ls [7]ades [8]eret [9]reserved
- mem_pc_i  in  32  PC of the MEM instruction
- mem_in_delayslot_i  in  1  MEM instruction is in a delay slot
- mem_bad_addr_i  in  32  faulting address: PC for adel_if, data address for adel_ls/ades
- cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current CP0 values
- wb_cp0_we_i  in  1  WB-stage CP0 write enable, used for forwarding
- wb_cp0_waddr_i  in  5  WB-stage CP0 write address
- wb_cp0_data_i  in  32  WB-stage CP0 write data
- excepttype_o  out  32  exception code to CP0
- current_inst_addr_o  out  32  to CP0
- is_in_delayslot_o  out  1  to CP0
- bad_addr_o  out  32  to CP0
- flush_o  out  1  pipeline flush
- new_pc_o  out  32  redirect target, valid while flush_o is high

Behaviour:
- Reset: every output is 0, state is IDLE, flush counter is 0. A reset asserted mid-flush aborts the flush on the next edge.
- Forwarding: if wb_cp0_we_i is set and wb_cp0_waddr_i equals the Status, Cause or EPC address, the effective value of that register is wb_cp0_data_i. For Cause, only bits 9:8 are replaced. Otherwise the effective value is the cp0_*_i input.
- Interrupt pending: status[0]=1 AND status[1]=0 AND ((cause[15:10] | int_i) & status[15:10]) != 0, OR ((cause[9:8] & status[9:8]) != 0 under the same IE/EXL gate).
- Take condition: state is IDLE, mem_valid_i=1, mem_stall_i=0, and (interrupt pending OR any mem_exc_i[8:0] bit set).
- Priority, highest first, with codes:
  - interrupt 0x01
  - adel_if 0x04
  - ri 0x0a
  - ov 0x0c
  - trap 0x0d
  - syscall 0x08
  - break 0x09
  - adel_ls 0x04
  - ades 0x05
  - eret 0x0e
- Take timing: when the take condition holds in cycle N, the following are registered at edge N+1:
  - excepttype_o = selected code
  - current_inst_addr_o = mem_pc_i
  - is_in_delayslot_o = mem_in_delayslot_i
  - bad_addr_o = mem_bad_addr_i for 0x04/0x05, otherwise 0
  - flush_o = 1
  - new_pc_o = effective EPC for 0x0e, otherwise EXC_VECTOR
  - state -> FLUSH, counter = FLUSH_CYCLES-1
- Exception-type pulse: excepttype_o returns to 0 one cycle after assertion, independent of FLUSH_CYCLES.
- FLUSH state:
  - Take detection is suppressed; flushed instructions never raise exceptions.
  - Counter decrements each cycle.
  - When counter=0, the next edge clears flush_o and new_pc_o and returns to IDLE.
  - The earliest next take is in the first IDLE cycle.
- Stall: mem_stall_i=1 in IDLE blocks the take. Pending conditions are re-evaluated each cycle with no latching of exceptions; an interrupt that disappears while stalled is lost.
- Bubbles: mem_valid_i=0 blocks interrupts too, so EPC always names a real instruction.
- No combinational path from any input to any output.

Optional Feature:
- Macro: EXC_CTRL_IRQ_SYNC_EN.
- Defined: int_i passes through a 2-flop synchronizer (reset to 0) before the pending check, adding 2 cycles of interrupt latency.
- Undefined: int_i is used directly. Exception-flag timing is identical in both builds.

Decomposition:
- Shared defines.vh additions:
  - exception code constants EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV, EXC_TR, EXC_ERET
  - the mem_exc_i bit-index constants
- Existing CP0 register-address constants are reused.
- One combinational sub-module, exc_prio_enc: takes the flag vector plus interrupt pending and returns the 32-bit code plus a take bit.

Test Plan:
- syscall at pc=0x00400010, valid, no stall -> next cycle excepttype_o=0x08, current_inst_addr_o=0x00400010, flush_o=1, new_pc_o=0xBFC00380; excepttype_o=0 the cycle after.
- ri and ov set together, with mem_in_delayslot_i=1 -> code 0x0a, is_in_delayslot_o=1.
- status=0x0000FC01, int_i=6'b000001, valid -> code 0x01. Repeat with status[1]=1 -> no take.
- eret with cp0_epc_i=0x100, wb writing EPC=0x200 in the same cycle -> new_pc_o=0x200, code 0x0e.
- FLUSH_CYCLES=3, syscall followed next cycle by break -> flush_o high exactly 3 cycles, break ignored, exactly one CP0 pulse.
- rst asserted during FLUSH -> all outputs 0 next cycle. Separately, mem_stall_i=1 with ades set -> no take until the stall drops, then code 0x05 with bad_addr_o = the data address.
